// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   M-stage data-memory access unit. Converts load/store requests from the
//   E/M register into a req/ready data-memory transaction, drives byte lanes
//   and strobes for stores, and aligns/extends load data for pipeline_W.
//   While a transaction waits it stalls F..M and kills the W-stage register
//   write. It flags misaligned accesses combinationally and raises a
//   registered one-cycle bus error when the memory does not answer in time.
//
// Parameters
//   TIMEOUT_CYCLES  WAIT cycles allowed before a bus error (>= 1)
//   CNT_W           wait-counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   CLK, RESET          clock (rising edge), synchronous active-high reset
//   MemReadM/MemWriteM  load / store present in M
//   Funct3M             access size and signedness (B,H,W,BU,HU)
//   ALUResultM          byte address
//   WriteDataM          store data, LSB-justified
//   DMemReq/We/Addr/WStrb/WData   memory request side
//   DMemRData/DMemReady           memory response side
//   ReadDataM           aligned, extended load result
//   StallM              freeze F..M this cycle
//   KillWM              suppress RegWrite into pipeline_W this cycle
//   MisalignM           misaligned access presented (combinational)
//   BusErrM             bus timeout (registered one-cycle pulse)
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        DMemReq,
  output logic        DMemWe,
  output logic [31:0] DMemAddr,
  output logic [3:0]  DMemWStrb,
  output logic [31:0] DMemWData,
  input  logic [31:0] DMemRData,
  input  logic        DMemReady,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        KillWM,
  output logic        MisalignM,
  output logic        BusErrM
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_buserr;
  logic             w_buserr_nxt;

  logic             w_is_byte;
  logic             w_is_half;
  logic             w_unsigned;
  logic             w_access;
  logic             w_misalign;
  logic             w_valid;
  logic             w_req;
  logic             w_stall;
  logic             w_kill;
  logic             w_done;
  logic [3:0]       w_strb;
  logic [31:0]      w_wdata;
  logic [7:0]       w_lbyte;
  logic [15:0]      w_lhalf;
  logic [31:0]      w_load_ext;

  // Size decode; any encoding other than B/H/BU/HU behaves as a word access.
  assign w_is_byte  = (Funct3M == 3'b000) | (Funct3M == 3'b100);
  assign w_is_half  = (Funct3M == 3'b001) | (Funct3M == 3'b101);
  assign w_unsigned = Funct3M[2];

  assign w_access   = MemReadM | MemWriteM;
  assign w_misalign = w_is_half ? ALUResultM[0]
                                : (~w_is_byte & (ALUResultM[1:0] != 2'b00));
  assign w_valid    = w_access & ~w_misalign & ~RESET;

  // Store lanes: data replicated across the word, strobes pick the lanes.
  always_comb begin
    w_wdata = WriteDataM;
    w_strb  = 4'b1111;
    if (w_is_byte) begin
      w_wdata = {4{WriteDataM[7:0]}};
      w_strb  = 4'b0001 << ALUResultM[1:0];
    end else if (w_is_half) begin
      w_wdata = {2{WriteDataM[15:0]}};
      w_strb  = ALUResultM[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Load alignment and sign/zero extension.
  always_comb begin
    case (ALUResultM[1:0])
      2'b00:   w_lbyte = DMemRData[7:0];
      2'b01:   w_lbyte = DMemRData[15:8];
      2'b10:   w_lbyte = DMemRData[23:16];
      default: w_lbyte = DMemRData[31:24];
    endcase
    w_lhalf = ALUResultM[1] ? DMemRData[31:16] : DMemRData[15:0];
    if (w_is_byte) begin
      w_load_ext = w_unsigned ? {24'b0, w_lbyte} : {{24{w_lbyte[7]}}, w_lbyte};
    end else if (w_is_half) begin
      w_load_ext = w_unsigned ? {16'b0, w_lhalf} : {{16{w_lhalf[15]}}, w_lhalf};
    end else begin
      w_load_ext = DMemRData;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_buserr_nxt = 1'b0;
    w_req        = 1'b0;
    w_stall      = 1'b0;
    w_kill       = 1'b0;
    w_done       = 1'b0;
    if (RESET) begin
      // Any outstanding transaction is abandoned, never retried.
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_cnt_nxt = '0;
          if (w_valid) begin
            w_req = 1'b1;
            if (DMemReady) begin
              w_done = 1'b1;
            end else begin
              w_stall     = 1'b1;
              w_kill      = 1'b1;
              w_state_nxt = S_WAIT;
              w_cnt_nxt   = CNT_W'(1);
            end
          end
        end
        default: begin
          // Inputs are frozen by StallM, so addr/data/strobes stay stable.
          if (DMemReady) begin
            w_req       = 1'b1;
            w_done      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == TIMEOUT_C) begin
            // Release the pipe but keep the bogus result out of W.
            w_kill       = 1'b1;
            w_buserr_nxt = 1'b1;
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
          end else begin
            w_req     = 1'b1;
            w_stall   = 1'b1;
            w_kill    = 1'b1;
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_buserr <= w_buserr_nxt;
    end
  end

  assign DMemReq   = w_req;
  assign DMemWe    = w_req & MemWriteM;
  assign DMemAddr  = {ALUResultM[31:2], 2'b00};
  assign DMemWStrb = (w_req & MemWriteM) ? w_strb : 4'b0000;
  assign DMemWData = w_wdata;
  assign ReadDataM = (w_done & MemReadM) ? w_load_ext : 32'h0;
  assign StallM    = w_stall;
  assign KillWM    = w_kill;
  assign MisalignM = w_access & w_misalign & ~RESET;
  assign BusErrM   = r_buserr & ~RESET;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int TO = 4;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_X  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_Y  = 3'b110;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = 3'b010;
  logic [31:0] ALUResultM = 32'h0;
  logic [31:0] WriteDataM = 32'h0;
  logic        DMemReq;
  logic        DMemWe;
  logic [31:0] DMemAddr;
  logic [3:0]  DMemWStrb;
  logic [31:0] DMemWData;
  logic [31:0] DMemRData = 32'h0;
  logic        DMemReady = 1'b0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        KillWM;
  logic        MisalignM;
  logic        BusErrM;

  always #5 CLK = ~CLK;

  mem_access_unit #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .Funct3M   (Funct3M),
    .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM),
    .DMemReq   (DMemReq),
    .DMemWe    (DMemWe),
    .DMemAddr  (DMemAddr),
    .DMemWStrb (DMemWStrb),
    .DMemWData (DMemWData),
    .DMemRData (DMemRData),
    .DMemReady (DMemReady),
    .ReadDataM (ReadDataM),
    .StallM    (StallM),
    .KillWM    (KillWM),
    .MisalignM (MisalignM),
    .BusErrM   (BusErrM)
  );

  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        kill;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc_n  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    if (obs === expv) n_pass++;
    else $display("FAIL %s (cycle %0d): got 0x%08h, want 0x%08h", tag, cyc_n, obs, expv);
  endtask

  task automatic drive(input logic rst, input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] rdata,
                       input logic rdy);
    @(posedge CLK);
    #1;
    RESET      = rst;
    MemReadM   = rd;
    MemWriteM  = wr;
    Funct3M    = f3;
    ALUResultM = a;
    WriteDataM = wd;
    DMemRData  = rdata;
    DMemReady  = rdy;
  endtask

  task automatic expect_o(input logic req, input logic we, input logic [3:0] strb,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input logic stall, input logic kill, input logic mis,
                          input logic berr);
    exp_t e;
    e.req   = req;
    e.we    = we;
    e.addr  = {ALUResultM[31:2], 2'b00};
    e.strb  = strb;
    e.wdata = wdata;
    e.rdata = rdata;
    e.stall = stall;
    e.kill  = kill;
    e.mis   = mis;
    e.berr  = berr;
    sb_q.push_back(e);
  endtask

  // Outputs are combinational off inputs driven just after posedge; compare mid-cycle.
  always @(negedge CLK) begin
    if (sb_q.size() > 0) begin
      cyc_n++;
      mon_e = sb_q.pop_front();
      check("req",   32'(DMemReq),   32'(mon_e.req));
      check("we",    32'(DMemWe),    32'(mon_e.we));
      check("addr",  DMemAddr,       mon_e.addr);
      check("strb",  32'(DMemWStrb), 32'(mon_e.strb));
      check("wdata", DMemWData,      mon_e.wdata);
      check("rdata", ReadDataM,      mon_e.rdata);
      check("stall", 32'(StallM),    32'(mon_e.stall));
      check("kill",  32'(KillWM),    32'(mon_e.kill));
      check("mis",   32'(MisalignM), 32'(mon_e.mis));
      check("berr",  32'(BusErrM),   32'(mon_e.berr));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_chk=%0d", n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset: everything quiet even with a load presented
    drive(1, 1, 0, F_W, 32'h100, 0, 32'hDEADBEEF, 1); expect_o(0,0,4'h0,0,0,0,0,0,0);
    drive(1, 1, 0, F_W, 32'h100, 0, 32'hDEADBEEF, 0); expect_o(0,0,4'h0,0,0,0,0,0,0);

    // zero-wait loads
    drive(0, 1, 0, F_W,  32'h100, 0, 32'hDEADBEEF, 1); expect_o(1,0,4'h0,0,32'hDEADBEEF,0,0,0,0);
    drive(0, 1, 0, F_B,  32'h103, 0, 32'h80FF1234, 1); expect_o(1,0,4'h0,0,32'hFFFFFF80,0,0,0,0);
    drive(0, 1, 0, F_BU, 32'h103, 0, 32'h80FF1234, 1); expect_o(1,0,4'h0,0,32'h00000080,0,0,0,0);
    drive(0, 1, 0, F_H,  32'h102, 0, 32'h80FF1234, 1); expect_o(1,0,4'h0,0,32'hFFFF80FF,0,0,0,0);
    drive(0, 1, 0, F_HU, 32'h100, 0, 32'h80FF9234, 1); expect_o(1,0,4'h0,0,32'h00009234,0,0,0,0);
    drive(0, 1, 0, F_B,  32'h101, 0, 32'h80FF1234, 1); expect_o(1,0,4'h0,0,32'h00000012,0,0,0,0);

    // zero-wait stores
    drive(0, 0, 1, F_H, 32'h102, 32'h0000ABCD, 32'h11111111, 1); expect_o(1,1,4'b1100,32'hABCDABCD,0,0,0,0,0);
    drive(0, 0, 1, F_H, 32'h100, 32'h00001357, 0, 1);            expect_o(1,1,4'b0011,32'h13571357,0,0,0,0,0);
    drive(0, 0, 1, F_B, 32'h101, 32'h12345677, 0, 1);            expect_o(1,1,4'b0010,32'h77777777,0,0,0,0,0);
    drive(0, 0, 1, F_B, 32'h103, 32'h000000A5, 0, 1);            expect_o(1,1,4'b1000,32'hA5A5A5A5,0,0,0,0,0);
    drive(0, 0, 1, F_W, 32'h200, 32'hCAFEF00D, 0, 1);            expect_o(1,1,4'b1111,32'hCAFEF00D,0,0,0,0,0);

    // load with three wait states
    drive(0, 1, 0, F_W, 32'h104, 0, 0, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h104, 0, 0, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h104, 0, 0, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h104, 0, 32'h11223344, 1); expect_o(1,0,4'h0,0,32'h11223344,0,0,0,0);

    // ready with no request is ignored
    drive(0, 0, 0, F_W, 32'h104, 0, 32'hFFFFFFFF, 1); expect_o(0,0,4'h0,0,0,0,0,0,0);

    // store with one wait state
    drive(0, 0, 1, F_B, 32'h102, 32'h0000005A, 0, 0); expect_o(1,1,4'b0100,32'h5A5A5A5A,0,1,1,0,0);
    drive(0, 0, 1, F_B, 32'h102, 32'h0000005A, 0, 1); expect_o(1,1,4'b0100,32'h5A5A5A5A,0,0,0,0,0);

    // timeout: 4 stall cycles, release with kill, then bus-error pulse
    drive(0, 1, 0, F_W, 32'h108, 0, 32'h55555555, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h108, 0, 32'h55555555, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h108, 0, 32'h55555555, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h108, 0, 32'h55555555, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(0, 1, 0, F_W, 32'h108, 0, 32'h55555555, 0); expect_o(0,0,4'h0,0,0,0,1,0,0);
    drive(0, 0, 0, F_W, 32'h10C, 0, 0, 0);            expect_o(0,0,4'h0,0,0,0,0,0,1);
    drive(0, 0, 0, F_W, 32'h10C, 0, 0, 0);            expect_o(0,0,4'h0,0,0,0,0,0,0);

    // misaligned accesses
    drive(0, 1, 0, F_H,  32'h101, 0, 32'h12345678, 1); expect_o(0,0,4'h0,0,0,0,0,1,0);
    drive(0, 1, 0, F_HU, 32'h103, 0, 32'h12345678, 1); expect_o(0,0,4'h0,0,0,0,0,1,0);
    drive(0, 0, 1, F_W,  32'h102, 32'hCAFEF00D, 0, 1); expect_o(0,0,4'h0,32'hCAFEF00D,0,0,0,1,0);
    drive(0, 1, 0, F_W,  32'h101, 0, 32'h12345678, 1); expect_o(0,0,4'h0,0,0,0,0,1,0);

    // undefined Funct3 behaves as word
    drive(0, 1, 0, F_X, 32'h10A, 0, 32'h12345678, 1); expect_o(0,0,4'h0,0,0,0,0,1,0);
    drive(0, 1, 0, F_Y, 32'h10C, 0, 32'h80000001, 1); expect_o(1,0,4'h0,0,32'h80000001,0,0,0,0);

    // reset during WAIT abandons the transaction
    drive(0, 1, 0, F_W, 32'h10C, 0, 0, 0); expect_o(1,0,4'h0,0,0,1,1,0,0);
    drive(1, 1, 0, F_W, 32'h10C, 0, 0, 0); expect_o(0,0,4'h0,0,0,0,0,0,0);
    drive(1, 1, 0, F_H, 32'h101, 0, 0, 0); expect_o(0,0,4'h0,0,0,0,0,0,0);
    drive(0, 0, 0, F_W, 32'h10C, 0, 0, 0); expect_o(0,0,4'h0,0,0,0,0,0,0);
    drive(0, 1, 0, F_W, 32'h10C, 0, 32'h0BADF00D, 1); expect_o(1,0,4'h0,0,32'h0BADF00D,0,0,0,0);

    drive(0, 0, 0, F_W, 32'h0, 0, 0, 0); expect_o(0,0,4'h0,0,0,0,0,0,0);
    repeat (3) @(negedge CLK);
    check("sb_drain", 32'(sb_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
